// File: rtl/game_state_controller.sv
// game_state_controller
// Frame-rate sequencer for VGA air-hockey. It tracks both scores, the serve
// delay, pause and game-over, and drives gameState for the ball and paddle
// stages. Every state change happens on the one-cycle vSyncStart pulse, so
// the game advances exactly once per frame.
//
// Ports:
//   pixelClock               single clock domain
//   resetN                   asynchronous active-low reset
//   vSyncStart               one-cycle per-frame pulse; the only update enable
//   buttons[7:0]             bit0 = start, bit1 = pause, other bits unused
//   collisionBallScreenLeft  ball touches the left edge (computer scores)
//   collisionBallScreenRight ball touches the right edge (player scores)
//   gameState[7:0]           0 title, 1 playing, 2 point scored, 3 game over, 4 paused
//   playerScore[3:0]         player points
//   computerScore[3:0]       computer points
//   winner                   0 = player, 1 = computer (meaningful in game over)
//   serveSide                side that conceded the last point (0 left, 1 right)
module game_state_controller #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       vSyncStart,
  input  logic [7:0] buttons,
  input  logic       collisionBallScreenLeft,
  input  logic       collisionBallScreenRight,
  output logic [7:0] gameState,
  output logic [3:0] playerScore,
  output logic [3:0] computerScore,
  output logic       winner,
  output logic       serveSide
);

  localparam logic [7:0] stateTitle       = 8'd0;
  localparam logic [7:0] statePlaying     = 8'd1;
  localparam logic [7:0] statePointScored = 8'd2;
  localparam logic [7:0] stateGameOver    = 8'd3;
  localparam logic [7:0] statePaused      = 8'd4;

  localparam logic [3:0] winScore  = 4'(WIN_SCORE);
  localparam logic [7:0] serveLoad = 8'(SERVE_FRAMES);

  logic [7:0] serveCounter;
  logic [1:0] prevButtons;

  logic [7:0] nextState;
  logic [7:0] nextServeCounter;
  logic [1:0] nextPrevButtons;
  logic [3:0] nextPlayerScore;
  logic [3:0] nextComputerScore;
  logic       nextWinner;
  logic       nextServeSide;

  logic       startPress;
  logic       pausePress;
  logic       leftOnly;
  logic       rightOnly;
  logic [3:0] playerInc;
  logic [3:0] computerInc;
  logic       unusedButtons;

  // Rising-edge press detection against the value seen on the previous frame
  assign startPress    = buttons[0] & ~prevButtons[0];
  assign pausePress    = buttons[1] & ~prevButtons[1];
  assign unusedButtons = ^buttons[7:2];

  // Simultaneous left and right hits cancel out and score nothing
  assign leftOnly  = collisionBallScreenLeft & ~collisionBallScreenRight;
  assign rightOnly = collisionBallScreenRight & ~collisionBallScreenLeft;

  assign playerInc   = playerScore + 4'd1;
  assign computerInc = computerScore + 4'd1;

  // State and datapath registers
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      gameState     <= stateTitle;
      playerScore   <= 4'd0;
      computerScore <= 4'd0;
      winner        <= 1'b0;
      serveSide     <= 1'b0;
      serveCounter  <= 8'd0;
      // Held buttons during reset must not look like a fresh press
      prevButtons   <= 2'b11;
    end else begin
      gameState     <= nextState;
      playerScore   <= nextPlayerScore;
      computerScore <= nextComputerScore;
      winner        <= nextWinner;
      serveSide     <= nextServeSide;
      serveCounter  <= nextServeCounter;
      prevButtons   <= nextPrevButtons;
    end
  end

  // Next-state and datapath update, gated by the frame pulse
  always_comb begin
    nextState         = gameState;
    nextServeCounter  = serveCounter;
    nextPrevButtons   = prevButtons;
    nextPlayerScore   = playerScore;
    nextComputerScore = computerScore;
    nextWinner        = winner;
    nextServeSide     = serveSide;

    if (vSyncStart) begin
      nextPrevButtons = buttons[1:0];
      case (gameState)
        stateTitle: begin
          if (startPress) begin
            nextPlayerScore   = 4'd0;
            nextComputerScore = 4'd0;
            nextServeCounter  = serveLoad;
            nextState         = statePointScored;
          end
        end
        statePlaying: begin
          if (pausePress) begin
            nextState = statePaused;
          end else if (leftOnly) begin
            nextComputerScore = computerInc;
            nextServeSide     = 1'b0;
            if (computerInc == winScore) begin
              nextWinner = 1'b1;
              nextState  = stateGameOver;
            end else begin
              nextServeCounter = serveLoad;
              nextState        = statePointScored;
            end
          end else if (rightOnly) begin
            nextPlayerScore = playerInc;
            nextServeSide   = 1'b1;
            if (playerInc == winScore) begin
              nextWinner = 1'b0;
              nextState  = stateGameOver;
            end else begin
              nextServeCounter = serveLoad;
              nextState        = statePointScored;
            end
          end
        end
        statePointScored: begin
          // Last serve frame releases play and leaves the counter at zero
          if (serveCounter == 8'd1) begin
            nextServeCounter = 8'd0;
            nextState        = statePlaying;
          end else begin
            nextServeCounter = serveCounter - 8'd1;
          end
        end
        statePaused: begin
          if (pausePress) begin
            nextState = statePlaying;
          end
        end
        stateGameOver: begin
          if (startPress) begin
            nextState = stateTitle;
          end
        end
        default: begin
          nextState = stateTitle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench for game_state_controller: a frame-level reference
// model checked every cycle, plus directed hand-computed expectations.
module tb_game_state_controller;

  localparam int unsigned WIN   = 2;
  localparam int unsigned SERVE = 6;

  logic       pixelClock;
  logic       resetN;
  logic       vSyncStart;
  logic [7:0] buttons;
  logic       collL;
  logic       collR;
  logic [7:0] gameState;
  logic [3:0] playerScore;
  logic [3:0] computerScore;
  logic       winner;
  logic       serveSide;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  game_state_controller #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE)) dut (
    .pixelClock               (pixelClock),
    .resetN                   (resetN),
    .vSyncStart               (vSyncStart),
    .buttons                  (buttons),
    .collisionBallScreenLeft  (collL),
    .collisionBallScreenRight (collR),
    .gameState                (gameState),
    .playerScore              (playerScore),
    .computerScore            (computerScore),
    .winner                   (winner),
    .serveSide                (serveSide)
  );

  initial begin
    pixelClock = 1'b0;
    forever #5 pixelClock = ~pixelClock;
  end

  // Reference model: game rules applied once per frame
  int mState;
  int mPlayer;
  int mComputer;
  int mWinner;
  int mServeSide;
  int mServeLeft;
  bit mHeldStart;
  bit mHeldPause;

  always @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      mState = 0; mPlayer = 0; mComputer = 0; mWinner = 0; mServeSide = 0;
      mServeLeft = 0; mHeldStart = 1; mHeldPause = 1;
    end else if (vSyncStart) begin
      bit sp, pp;
      sp = buttons[0] && !mHeldStart;
      pp = buttons[1] && !mHeldPause;
      mHeldStart = buttons[0];
      mHeldPause = buttons[1];
      if (mState == 0) begin
        if (sp) begin
          mPlayer = 0; mComputer = 0; mServeLeft = SERVE; mState = 2;
        end
      end else if (mState == 1) begin
        if (pp) mState = 4;
        else if (collL != collR) begin
          int pts;
          if (collL) begin mComputer++; mServeSide = 0; pts = mComputer; end
          else       begin mPlayer++;   mServeSide = 1; pts = mPlayer;   end
          if (pts == WIN) begin mState = 3; mWinner = collL ? 1 : 0; end
          else begin mServeLeft = SERVE; mState = 2; end
        end
      end else if (mState == 2) begin
        mServeLeft--;
        if (mServeLeft == 0) mState = 1;
      end else if (mState == 4) begin
        if (pp) mState = 1;
      end else if (mState == 3) begin
        if (sp) mState = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge pixelClock) begin
    if (started) begin
      check("model.gameState", int'(gameState), mState);
      check("model.scores", int'({playerScore, computerScore}), mPlayer * 16 + mComputer);
      check("model.winner", int'(winner), mWinner);
      check("model.serveSide", int'(serveSide), mServeSide);
    end
  end

  // One frame: vSync cycle with the given inputs, then three quiet cycles
  // carrying random collision noise that must be ignored.
  task automatic frame(input logic [7:0] b, input logic l, input logic r);
    @(negedge pixelClock);
    buttons = b; collL = l; collR = r; vSyncStart = 1'b1;
    @(negedge pixelClock);
    vSyncStart = 1'b0;
    repeat (3) begin
      collL = 1'($urandom);
      collR = 1'($urandom);
      @(negedge pixelClock);
    end
    collL = 1'b0; collR = 1'b0;
  endtask

  task automatic expectAll(input string name, input int st, input int ps, input int cs);
    check({name, ".state"}, int'(gameState), st);
    check({name, ".player"}, int'(playerScore), ps);
    check({name, ".computer"}, int'(computerScore), cs);
  endtask

  initial begin
    resetN = 1'b0; vSyncStart = 1'b0; buttons = 8'h00; collL = 1'b0; collR = 1'b0;
    repeat (3) @(negedge pixelClock);
    started = 1;
    expectAll("reset", 0, 0, 0);
    check("reset.winner", int'(winner), 0);
    check("reset.serveSide", int'(serveSide), 0);
    resetN = 1'b1;

    // Opening serve
    frame(8'h00, 0, 0);
    expectAll("idle", 0, 0, 0);
    frame(8'h01, 0, 0);
    expectAll("start", 2, 0, 0);
    for (int i = 0; i < int'(SERVE) - 1; i++) frame(8'h00, 0, 0);
    check("serve.stillHeld", int'(gameState), 2);
    frame(8'h00, 0, 0);
    expectAll("serve.release", 1, 0, 0);

    // Player point from a right-edge hit
    frame(8'h00, 0, 1);
    expectAll("right", 2, 1, 0);
    check("right.serveSide", int'(serveSide), 1);
    for (int i = 0; i < int'(SERVE); i++) frame(8'h00, 0, 0);
    check("right.backToPlay", int'(gameState), 1);

    // Computer point from a left-edge hit
    frame(8'h00, 1, 0);
    expectAll("left", 2, 1, 1);
    check("left.serveSide", int'(serveSide), 0);
    for (int i = 0; i < int'(SERVE); i++) frame(8'h00, 0, 0);

    // Pause wins over a same-frame collision
    frame(8'h02, 1, 0);
    expectAll("pause", 4, 1, 1);
    frame(8'h03, 0, 0);
    check("pause.startIgnored", int'(gameState), 4);
    frame(8'h00, 0, 0);
    frame(8'h02, 0, 0);
    check("unpause", int'(gameState), 1);
    frame(8'h00, 0, 0);

    // Both edges in one frame score nothing
    frame(8'h00, 1, 1);
    expectAll("both", 1, 1, 1);

    // Winning point for the computer
    frame(8'h00, 1, 0);
    expectAll("win", 3, 1, 2);
    check("win.winner", int'(winner), 1);
    frame(8'h00, 1, 0);
    expectAll("over.hold", 3, 1, 2);
    frame(8'h01, 0, 0);
    expectAll("over.toTitle", 0, 1, 2);
    frame(8'h00, 0, 0);

    // Held start: exactly one transition, normal serve countdown
    frame(8'h01, 0, 0);
    expectAll("held.first", 2, 0, 0);
    for (int i = 0; i < 9; i++) frame(8'h01, 0, 0);
    expectAll("held.tenth", 1, 0, 0);
    frame(8'h00, 0, 0);

    // Asynchronous reset in the middle of a serve
    frame(8'h00, 0, 1);
    frame(8'h00, 0, 0);
    check("midServe.state", int'(gameState), 2);
    check("midServe.player", int'(playerScore), 1);
    buttons = 8'h01;
    @(negedge pixelClock);
    #2 resetN = 1'b0;
    #1;
    expectAll("asyncReset", 0, 0, 0);
    check("asyncReset.serveSide", int'(serveSide), 0);
    check("asyncReset.winner", int'(winner), 0);
    @(negedge pixelClock);
    resetN = 1'b1;

    // Start held through reset must not count as a press
    frame(8'h01, 0, 0);
    check("heldThroughReset", int'(gameState), 0);
    frame(8'h00, 0, 0);
    frame(8'h01, 0, 0);
    check("startAfterReset", int'(gameState), 2);

    repeat (2) @(negedge pixelClock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Frame-rate game sequencer for VGA air-hockey. Consumes ball-vs-screen-edge collision flags and controller buttons, keeps both scores, and drives `gameState`, which the ball and paddle stages use to decide whether to move or to recentre. All state changes occur on the one-cycle `vSyncStart` pulse, so the whole game advances exactly once per frame.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win; legal range 1–15.
- `SERVE_FRAMES`, 60: frames the ball is held centred after each point; legal range 1–255.

Ports:
- `pixelClock`  in  1  the single clock domain.
- `resetN`  in  1  asynchronous, active-low reset.
- `vSyncStart`  in  1  one-cycle pulse per frame; the only update enable.
- `buttons`  in  8  bit0 = start, bit1 = pause; other bits are ignored.
- `collisionBallScreenLeft`  in  1  ball touches the left edge (player goal).
- `collisionBallScreenRight`  in  1  ball touches the right edge (computer goal).
- `gameState`  out  8  state code: 0 stateTitle, 1 statePlaying, 2 statePointScored, 3 stateGameOver, 4 statePaused.
- `playerScore`  out  4  player points.
- `computerScore`  out  4  computer points.
- `winner`  out  1  0 = player, 1 = computer; valid only in stateGameOver.
- `serveSide`  out  1  side that conceded the last point (0 = left/player, 1 = right/computer).

## Operation
- Button edge detect:
  - Register `buttons[1:0]` into `prevButtons` on each `vSyncStart`.
  - `startPress` = `buttons[0] & ~prevButtons[0]`; `pausePress` is the same on bit1.
  - A held button produces exactly one press.
- Internal 8-bit `serveCounter`.
- FSM transitions (evaluated only when `vSyncStart` = 1):
  - **stateTitle**: on `startPress`, clear both scores, load `serveCounter` = `SERVE_FRAMES`, and go to statePointScored. This gives the opening serve delay.
  - **statePlaying**:
    - `pausePress` has top priority and goes to statePaused; collisions in that frame are ignored.
    - Left only: increment `computerScore`, set `serveSide` = 0.
    - Right only: increment `playerScore`, set `serveSide` = 1.
    - Both left and right in the same frame: no score, stay in statePlaying.
    - After a score: if the new score equals `WIN_SCORE`, go to stateGameOver and set `winner` to the scorer. Otherwise load `serveCounter` = `SERVE_FRAMES` and go to statePointScored.
  - **statePointScored**:
    - Collisions are ignored; the ball is centred by downstream logic because the state is not statePlaying.
    - Decrement `serveCounter` each frame.
    - In the frame where `serveCounter` = 1, go to statePlaying and set the counter to 0.
  - **statePaused**: `pausePress` returns to statePlaying; `startPress` is ignored. Scores and `serveCounter` hold.
  - **stateGameOver**: scores and `winner` hold. `startPress` goes to stateTitle with scores unchanged; they are cleared on the next start.
- Scores never exceed `WIN_SCORE`, because the increment happens only in statePlaying and reaching the limit exits that state. No wrap-around is possible.
- Width rules:
  - Scores are 4-bit unsigned.
  - Compare against `WIN_SCORE[3:0]`.
  - `serveCounter` loads `SERVE_FRAMES[7:0]`.

## Timing
- Reset (asynchronous assert, any time, including mid-game or mid-serve):
  - `gameState` = 0 (stateTitle).
  - `playerScore` = `computerScore` = 0.
  - `winner` = 0, `serveSide` = 0.
  - `serveCounter` = 0, `prevButtons` = 2'b11. This suppresses a false press if a button is held during reset.
- Reset release is synchronous to `pixelClock`. The first update occurs on the first `vSyncStart` after release.
- All outputs are registered and change on the `pixelClock` edge where `vSyncStart` = 1. Latency from sampled input to output is 1 cycle.
- Outputs are stable for the whole frame. The ball stage samples `gameState` on the next `vSyncStart`, so a point recentres the ball one frame after the collision frame.
- Cycles with `vSyncStart` = 0 change nothing. Collision or button pulses that do not coincide with `vSyncStart` are not seen.
- Serve delay: exactly `SERVE_FRAMES` frames in statePointScored. Example: `SERVE_FRAMES` = 3 means the states observed are 2, 2, 2, then 1.

## Test plan
- Reset and start: hold `resetN` = 0 with `buttons` = 0, release, then set `buttons[0]` high for 1 frame. Expect `gameState` 0→2. With `SERVE_FRAMES` = 3, `gameState` = 1 on the 4th frame; scores = 0/0.
- Scoring: in statePlaying, pulse `collisionBallScreenRight` for one frame. Expect `playerScore` = 1, `serveSide` = 1, `gameState` = 2, then back to 1 after `SERVE_FRAMES` frames. Repeat with Left: `computerScore` = 1, `serveSide` = 0.
- Win: `WIN_SCORE` = 2; two computer points. Expect `gameState` = 3, `winner` = 1, `computerScore` = 2. A later start press gives `gameState` = 0; a second start press clears the scores.
- Pause and simultaneous events:
  - Pause press plus Left collision in the same frame: expect `gameState` = 4 and no score change.
  - A second pause press: expect `gameState` = 1.
  - Left plus Right in the same frame while playing: scores unchanged, state stays 1.
- Held button: hold `buttons[0]` high for 10 frames from stateTitle. Expect exactly one transition, with the serve counting down normally.
- Asynchronous reset mid-serve: assert `resetN` = 0 between clock edges while `gameState` = 2 and `serveCounter` = 5. All outputs go to reset values immediately, without waiting for a `pixelClock` edge.
